// File: rtl/rf_multiport.sv
// rf_multiport: register file with one write port and two registered read
// ports. After reset an init sweep loads every entry with INIT_VAL, so the
// array itself needs no per-entry reset and can map onto RAM.
module rf_multiport #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     DEPTH    = 16,
  parameter int unsigned     ADDR_W   = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter bit              BYPASS   = 1'b1,
  parameter bit              ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              ready,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_ok_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [WIDTH-1:0]  mem_wdata_c;
  logic [WIDTH-1:0]  rd_a_c;
  logic [WIDTH-1:0]  rd_b_c;

  function automatic logic in_range(input logic [ADDR_W-1:0] sel);
    return ({1'b0, sel} < DEPTH_W);
  endfunction

  // Read mux: out-of-range and hardwired-zero win over bypass, bypass over array.
  function automatic logic [WIDTH-1:0] rd_word(input logic [ADDR_W-1:0] sel,
                                               input logic [WIDTH-1:0]  stored,
                                               input logic              wr_ok,
                                               input logic [ADDR_W-1:0] wsel,
                                               input logic [WIDTH-1:0]  wdata);
    logic [WIDTH-1:0] w;
    w = '0;
    if (!in_range(sel) || (ZERO_REG && (sel == '0))) begin
      w = '0;
    end else if (BYPASS && wr_ok && (wsel == sel)) begin
      w = wdata;
    end else begin
      w = stored;
    end
    return w;
  endfunction

  // Write qualification, array write port steering and read data selection.
  always_comb begin
    wr_ok_c     = wr_en && in_range(wr_sel) && !(ZERO_REG && (wr_sel == '0));
    mem_we_c    = 1'b0;
    mem_addr_c  = wr_sel;
    mem_wdata_c = data_in;
    if (reset) begin
      if (state == ST_RUN) begin
        mem_we_c = wr_ok_c;
      end else begin
        mem_we_c    = 1'b1;
        mem_addr_c  = ptr;
        mem_wdata_c = INIT_VAL;
      end
    end
    rd_a_c = rd_word(rd_sel_a, mem[rd_sel_a], wr_ok_c, wr_sel, data_in);
    rd_b_c = rd_word(rd_sel_b, mem[rd_sel_b], wr_ok_c, wr_sel, data_in);
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
  end

  // Sweep/run control and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_INIT;
      ptr        <= '0;
      ready      <= 1'b0;
      wr_err     <= 1'b0;
      data_out_a <= '0;
      data_out_b <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr        <= ptr + ADDR_W'(1);
          wr_err     <= wr_en;
          data_out_a <= '0;
          data_out_b <= '0;
          if (ptr == LAST_IDX) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ready      <= 1'b1;
          wr_err     <= wr_en && !wr_ok_c;
          data_out_a <= rd_a_c;
          data_out_b <= rd_b_c;
        end
        default: begin
          state      <= ST_INIT;
          ptr        <= '0;
          ready      <= 1'b0;
          wr_err     <= 1'b0;
          data_out_a <= '0;
          data_out_b <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: four differently configured register files driven by the
// same stimulus, checked against a per-instance behavioural model through a
// scoreboard queue.
module tb_rf_multiport;

  localparam int unsigned NI = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_sel;
  logic [7:0] data_in;
  logic [3:0] rd_sel_a;
  logic [3:0] rd_sel_b;

  logic [NI-1:0][7:0] dout_a;
  logic [NI-1:0][7:0] dout_b;
  logic [NI-1:0]      rdy;
  logic [NI-1:0]      err;

  // Instance configuration: 0 default, 1 no bypass, 2 depth 12, 3 init 0x5A.
  int unsigned cfg_depth [NI] = '{16, 16, 12, 16};
  logic [7:0]  cfg_init  [NI] = '{8'h00, 8'h00, 8'h00, 8'h5A};
  bit          cfg_byp   [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

  typedef struct packed {
    logic [NI-1:0][7:0] a;
    logic [NI-1:0][7:0] b;
    logic [NI-1:0]      rdy;
    logic [NI-1:0]      err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_mem [NI][16];
  bit         m_run [NI];
  int         m_ptr [NI];

  int n_checks = 0;
  int n_errors = 0;

  rf_multiport #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .INIT_VAL(8'h00), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_def (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .data_out_a(dout_a[0]), .data_out_b(dout_b[0]),
    .ready(rdy[0]), .wr_err(err[0]));

  rf_multiport #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .INIT_VAL(8'h00), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nbp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .data_out_a(dout_a[1]), .data_out_b(dout_b[1]),
    .ready(rdy[1]), .wr_err(err[1]));

  rf_multiport #(.WIDTH(8), .DEPTH(12), .ADDR_W(4), .INIT_VAL(8'h00), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_d12 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .data_out_a(dout_a[2]), .data_out_b(dout_b[2]),
    .ready(rdy[2]), .wr_err(err[2]));

  rf_multiport #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .INIT_VAL(8'h5A), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_iv (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .data_out_a(dout_a[3]), .data_out_b(dout_b[3]),
    .ready(rdy[3]), .wr_err(err[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read result for instance i given the current inputs.
  function automatic logic [7:0] m_read(input int i, input logic [3:0] sel, input bit ok);
    if (32'(sel) >= cfg_depth[i] || sel == 4'd0) return 8'h00;
    if (ok && cfg_byp[i] && sel == wr_sel) return data_in;
    return m_mem[i][sel];
  endfunction

  // One clock: predict every instance's outputs, push, clock, pop and compare.
  task automatic cycle();
    exp_t e;
    exp_t got;
    bit   ok;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        m_run[i] = 1'b0;
        m_ptr[i] = 0;
      end else if (!m_run[i]) begin
        m_mem[i][m_ptr[i]] = cfg_init[i];
        e.err[i] = wr_en;
        if (m_ptr[i] == int'(cfg_depth[i]) - 1) m_run[i] = 1'b1;
        m_ptr[i]++;
        e.rdy[i] = m_run[i];
      end else begin
        ok = wr_en && (32'(wr_sel) < cfg_depth[i]) && (wr_sel != 4'd0);
        e.err[i] = wr_en && !ok;
        e.rdy[i] = 1'b1;
        e.a[i]   = m_read(i, rd_sel_a, ok);
        e.b[i]   = m_read(i, rd_sel_b, ok);
        if (ok) m_mem[i][wr_sel] = data_in;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("u%0d.ready", i), 32'(rdy[i]), 32'(got.rdy[i]));
        chk($sformatf("u%0d.wr_err", i), 32'(err[i]), 32'(got.err[i]));
        chk($sformatf("u%0d.data_out_a sel%0d", i, rd_sel_a), 32'(dout_a[i]), 32'(got.a[i]));
        chk($sformatf("u%0d.data_out_b sel%0d", i, rd_sel_b), 32'(dout_b[i]), 32'(got.b[i]));
      end
    end
  endtask

  task automatic drive(input logic we, input int ws, input logic [7:0] d, input int ra, input int rb);
    wr_en    = we;
    wr_sel   = 4'(ws);
    data_in  = d;
    rd_sel_a = 4'(ra);
    rd_sel_b = 4'(rb);
  endtask

  task automatic read_all();
    for (int s = 0; s < 16; s++) begin
      drive(1'b0, 0, 8'h00, s, 15 - s);
      cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 1'b0;
      m_ptr[i] = 0;
    end
    reset = 1'b0;
    drive(1'b0, 0, 8'h00, 0, 0);
    cycle();
    cycle();

    // Init sweep; a write attempt at ptr=3 must be dropped and flagged.
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(k == 3, 9, 8'hAA, k, 15 - k);
      cycle();
    end
    read_all();

    // Plain write then read.
    drive(1'b1, 5, 8'h09, 1, 1);  cycle();
    drive(1'b0, 0, 8'h00, 5, 5);  cycle();

    // Same-cycle write/read collision on both ports, then read back.
    drive(1'b1, 2, 8'h06, 2, 2);  cycle();
    drive(1'b0, 0, 8'h00, 2, 2);  cycle();

    // Zero register write rejected, out-of-range write/read.
    drive(1'b1, 0, 8'h07, 0, 3);  cycle();
    drive(1'b0, 0, 8'h00, 0, 3);  cycle();
    drive(1'b1, 13, 8'h33, 4, 13); cycle();
    drive(1'b0, 0, 8'h00, 13, 13); cycle();

    // Back-to-back rejected writes keep wr_err high.
    drive(1'b1, 0, 8'h11, 0, 0);  cycle();
    drive(1'b1, 15, 8'h22, 0, 15); cycle();
    drive(1'b1, 0, 8'h44, 0, 15); cycle();
    drive(1'b0, 0, 8'h00, 15, 0); cycle();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom()),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      cycle();
    end

    // Reset mid-run, then again mid-sweep at ptr=7.
    drive(1'b1, 5, 8'h0A, 5, 5);  cycle();
    drive(1'b0, 0, 8'h00, 5, 5);
    reset = 1'b0; cycle();
    reset = 1'b1;
    for (int k = 0; k < 7; k++) cycle();
    reset = 1'b0; cycle();
    reset = 1'b1;
    for (int k = 0; k < 16; k++) cycle();
    read_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised successor to the team's single-port 16x8 register file. It has one write port and two independent read ports. Reads are registered, with optional write-to-read bypass and an optional hardwired zero register. After reset, a sequential init sweep walks the array and loads every entry with INIT_VAL, so the storage can map to RAM without a per-entry reset. It sits between the datapath's operand-select logic and the ALU.

Parameters:
WIDTH, 8, data width of each entry
DEPTH, 16, number of entries (2..2^ADDR_W)
ADDR_W, 4, width of the select ports
INIT_VAL, 0, value written to every entry by the init sweep
BYPASS, 1, 1 = a read of the entry being written in the same cycle returns data_in; 0 = returns the old contents
ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are rejected

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset (sampled on the rising edge of clk)
wr_en  in  1  write request
wr_sel  in  ADDR_W  write address
data_in  in  WIDTH  write data
rd_sel_a  in  ADDR_W  read address, port A
rd_sel_b  in  ADDR_W  read address, port B
data_out_a  out  WIDTH  registered read data, port A
data_out_b  out  WIDTH  registered read data, port B
ready  out  1  1 = init sweep done, writes accepted
wr_err  out  1  one-cycle registered pulse when a write request is rejected

Behaviour:
- Reset (reset==0 at an edge):
  - state <= INIT, sweep pointer <= 0.
  - ready, wr_err, data_out_a and data_out_b <= 0.
  - Array contents are not touched directly.
  - Reset takes priority over everything else, including mid-sweep and mid-write.
- State INIT:
  - Each edge writes INIT_VAL to entry [ptr], then ptr <= ptr+1.
  - The edge that writes entry DEPTH-1 moves state to RUN and sets ready <= 1.
  - So ready is 1 after exactly DEPTH edges with reset high.
  - data_out_a and data_out_b are held at 0.
  - Any wr_en=1 is dropped, and wr_err=1 on the following cycle.
- State RUN:
  - A write occurs at the edge when wr_en=1 and the address is valid.
  - Reads take 1 cycle: data_out_x <= entry[rd_sel_x] at the edge after the address is presented.
  - Both read ports are fully independent and may select the same entry.
  - Same-cycle read/write collision, wr_en=1 and wr_sel==rd_sel_x: with BYPASS=1, data_out_x <= data_in; with BYPASS=0, data_out_x <= the pre-write contents.
  - ZERO_REG=1: a read of entry 0 returns 0, overriding bypass. A write to entry 0 is discarded and wr_err pulses.
  - wr_sel >= DEPTH: write dropped, wr_err pulses.
  - rd_sel_x >= DEPTH: data_out_x <= 0.
- wr_err:
  - Registered and high for exactly one cycle per rejected request.
  - Back-to-back rejected requests hold it high continuously.
  - It is 0 whenever wr_en=0.
- No other states exist. RUN persists until the next reset. An unreachable state encoding falls back to INIT.
- A reset asserted mid-run restarts the sweep from entry 0. All entries hold INIT_VAL after the sweep completes, and previously written data is lost.

Test Plan:
Defaults for all scenarios unless stated: WIDTH=8, DEPTH=16, INIT_VAL=0, BYPASS=1, ZERO_REG=1.
1. reset=0 for 2 edges, then 1 -> ready=0 for 15 edges and ready=1 after the 16th; data_out_a and data_out_b read 0 for every rd_sel 0..15.
2. After ready: wr_en=1, wr_sel=5, data_in=9; next cycle wr_en=0, rd_sel_a=5 -> data_out_a=9 one edge later.
3. wr_en=1, wr_sel=2, data_in=6, rd_sel_a=2, rd_sel_b=2 in the same cycle -> data_out_a=data_out_b=6 next cycle. Repeat with BYPASS=0 -> both read 0, then 6 on the following read.
4. wr_en=1, wr_sel=0, data_in=7 -> wr_err=1 for one cycle; a read of rd_sel_a=0 returns 0. With DEPTH=12, wr_sel=13 -> wr_err=1 for one cycle and rd_sel_b=13 reads 0.
5. During INIT (ptr=3): wr_en=1, wr_sel=9, data_in=0xAA -> wr_err=1 for one cycle; after ready, entry 9 reads 0. Repeat with INIT_VAL=0x5A -> every entry reads 0x5A.
6. In RUN: write entry 5 <= 10, then reset=0 for one edge -> ready=0 and outputs=0 next cycle; after 16 edges ready=1 and entry 5 reads 0. A reset asserted at ptr=7 restarts the sweep at ptr=0.
